// File: rtl/branch_ctrl.sv
// -----------------------------------------------------------------------------
// branch_ctrl
//   Resolve-stage branch controller. Decodes B, B.cond, CBZ and CBNZ, holds
//   the architectural NZCV register, and on a taken branch issues a one-cycle
//   fetch redirect followed by a fixed-length squash of the younger stages.
//   Instructions arriving while the squash is active are ignored.
//
// Parameters
//   N             PC / branch target width
//   FLUSH_CYCLES  number of cycles flush stays high after a taken branch (1..7)
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous, active-low reset
//   instr          instruction word in the resolve stage
//   instr_valid    instr is live this cycle
//   set_flags      instr writes NZCV (ADDS/SUBS/ANDS)
//   alu_flags      {N,Z,C,V} produced by instr
//   reg_zero       CBZ/CBNZ operand equals zero
//   branch_target  computed target of instr
//   pc_src         registered: select pc_target for the next fetch
//   pc_target      registered redirect address
//   flush          registered: squash all younger stages
//   flags_q        architectural NZCV register
//   taken_cnt      running count of taken branches (wraps)
// -----------------------------------------------------------------------------
module branch_ctrl #(
    parameter int N            = 64,
    parameter int FLUSH_CYCLES = 3
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [31:0]   instr,
    input  logic          instr_valid,
    input  logic          set_flags,
    input  logic [3:0]    alu_flags,
    input  logic          reg_zero,
    input  logic [N-1:0]  branch_target,
    output logic          pc_src,
    output logic [N-1:0]  pc_target,
    output logic          flush,
    output logic [3:0]    flags_q,
    output logic [31:0]   taken_cnt
);

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES);

    state_t        state, state_nxt;
    logic [2:0]    cnt, cnt_nxt;
    logic          pc_src_nxt;
    logic [N-1:0]  pc_target_nxt;
    logic          flush_nxt;
    logic [3:0]    flags_nxt;
    logic [31:0]   taken_cnt_nxt;

    logic          is_bcond_p0, is_cbz_p0, is_cbnz_p0, is_b_p0, is_branch_p0;
    logic          br_taken_p0, accept_p0, take_p0, flag_wr_p0;
    logic          unused_bits;

    // Immediate fields are resolved upstream; only opcode and cond matter here.
    assign unused_bits = ^instr[23:5];

    // Condition evaluation against the registered NZCV (no same-cycle bypass).
    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v;
        logic r;
        {n, z, c, v} = nzcv;
        case (cond)
            4'h0:    r = z;
            4'h1:    r = !z;
            4'h2:    r = c;
            4'h3:    r = !c;
            4'h4:    r = n;
            4'h5:    r = !n;
            4'h6:    r = v;
            4'h7:    r = !v;
            4'h8:    r = c & !z;
            4'h9:    r = !(c & !z);
            4'hA:    r = (n == v);
            4'hB:    r = (n != v);
            4'hC:    r = !z & (n == v);
            4'hD:    r = !(!z & (n == v));
            default: r = 1'b1;
        endcase
        return r;
    endfunction

    // Resolve stage: decode and branch outcome
    assign is_bcond_p0  = (instr[31:24] == 8'b0101_0100);
    assign is_cbz_p0    = (instr[31:24] == 8'b1011_0100);
    assign is_cbnz_p0   = (instr[31:24] == 8'b1011_0101);
    assign is_b_p0      = (instr[31:26] == 6'b000101);
    assign is_branch_p0 = is_bcond_p0 | is_cbz_p0 | is_cbnz_p0 | is_b_p0;

    // B.cond with bit 4 set is a reserved form and never branches.
    assign br_taken_p0 = (is_bcond_p0 & !instr[4] & cond_pass(instr[3:0], flags_q))
                       | (is_cbz_p0  &  reg_zero)
                       | (is_cbnz_p0 & !reg_zero)
                       |  is_b_p0;

    assign accept_p0  = (state == RUN) & instr_valid;
    assign take_p0    = accept_p0 & br_taken_p0;
    assign flag_wr_p0 = accept_p0 & set_flags & !is_branch_p0;

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        pc_src_nxt    = 1'b0;
        pc_target_nxt = pc_target;
        flush_nxt     = 1'b0;
        flags_nxt     = flags_q;
        taken_cnt_nxt = taken_cnt;
        case (state)
            RUN: begin
                if (take_p0) begin
                    state_nxt     = FLUSH;
                    cnt_nxt       = FLUSH_LOAD;
                    pc_src_nxt    = 1'b1;
                    pc_target_nxt = branch_target;
                    flush_nxt     = 1'b1;
                    taken_cnt_nxt = taken_cnt + 32'd1;
                end
                if (flag_wr_p0) begin
                    flags_nxt = alu_flags;
                end
            end
            FLUSH: begin
                // cnt holds the flush cycles still to run including this one.
                if (cnt == 3'd1) begin
                    state_nxt = RUN;
                    cnt_nxt   = 3'd0;
                end else begin
                    cnt_nxt   = cnt - 3'd1;
                    flush_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = RUN;
                cnt_nxt   = 3'd0;
            end
        endcase
    end

    // Output / state register stage
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= RUN;
            cnt       <= 3'd0;
            pc_src    <= 1'b0;
            pc_target <= '0;
            flush     <= 1'b0;
            flags_q   <= 4'b0000;
            taken_cnt <= 32'd0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            pc_src    <= pc_src_nxt;
            pc_target <= pc_target_nxt;
            flush     <= flush_nxt;
            flags_q   <= flags_nxt;
            taken_cnt <= taken_cnt_nxt;
        end
    end

endmodule
